// File: rtl/conv_pkg.sv
// Shared constants and FSM encoding for the convolution sequencer.
package conv_pkg;
  localparam int IDX_W    = 6;
  localparam int MAX_SIZE = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_e;
endpackage

// File: rtl/idx_cnt.sv
// Up-counter with synchronous clear/enable and a terminal-count compare.
module idx_cnt #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] tc_val,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == tc_val);
endmodule

// File: rtl/conv_seq_ctrl.sv
// Sequencer for z = x * y: walks i per output z, drives read/write indices and
// accumulator controls; valid terms reach mac_en one cycle late to match read latency.
module conv_seq_ctrl #(
  parameter int IDX_W    = conv_pkg::IDX_W,
  parameter int MAX_SIZE = conv_pkg::MAX_SIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] size_x,
  input  logic [IDX_W-1:0] size_y,
  output logic [IDX_W-1:0] x_ind_o,
  output logic [IDX_W-1:0] y_ind_o,
  output logic [IDX_W-1:0] z_ind_o,
  output logic             mac_clr,
  output logic             mac_en,
  output logic             z_we,
  output logic             busy,
  output logic             done,
  output logic             err
);
  import conv_pkg::*;

  localparam logic [IDX_W-1:0] MAX_SZ = IDX_W'(MAX_SIZE);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   sx_q, sx_d, sy_q, sy_d, y_ind_q, y_ind_d;
  logic               mac_en_q, mac_en_d, mac_clr_q, mac_clr_d, z_we_q, z_we_d;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [IDX_W-1:0]   i_cnt, z_cnt;
  logic               i_tc, z_tc, size_ok, accept, term_vld;
  logic signed [IDX_W:0] diff;

  assign size_ok = (size_x != '0) && (size_x <= MAX_SZ) &&
                   (size_y != '0) && (size_y <= MAX_SZ);
  assign accept  = (state_q == IDLE) && start && size_ok;

  // One extra bit so z-i goes negative instead of wrapping.
  assign diff     = $signed({1'b0, z_cnt}) - $signed({1'b0, i_cnt});
  assign term_vld = (state_q == RUN) && !diff[IDX_W] && (diff[IDX_W-1:0] < sy_q);

  idx_cnt #(.W(IDX_W)) u_i_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q != RUN),
    .en     ((state_q == RUN) && !i_tc),
    .tc_val (sx_q - IDX_W'(1)),
    .cnt_o  (i_cnt),
    .tc_o   (i_tc)
  );

  idx_cnt #(.W(IDX_W)) u_z_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     ((state_q == WRITE) && !z_tc),
    .tc_val (sx_q + sy_q - IDX_W'(2)),
    .cnt_o  (z_cnt),
    .tc_o   (z_tc)
  );

  always_comb begin
    state_d = state_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    y_ind_d = y_ind_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (size_ok) begin
          state_d = CLR;
          sx_d    = size_x;
          sy_d    = size_y;
        end else begin
          err_d   = 1'b1;
        end
      end
      CLR: begin
        state_d = RUN;
        y_ind_d = z_cnt;
      end
      RUN: begin
        y_ind_d = y_ind_q - IDX_W'(1);
        if (i_tc) state_d = DRAIN;
      end
      DRAIN:   state_d = WRITE;
      WRITE:   state_d = z_tc ? DONE : CLR;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    mac_en_d  = term_vld;
    mac_clr_d = (state_d == CLR);
    z_we_d    = (state_d == WRITE);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sx_q      <= '0;
      sy_q      <= '0;
      y_ind_q   <= '0;
      mac_en_q  <= 1'b0;
      mac_clr_q <= 1'b0;
      z_we_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      y_ind_q   <= y_ind_d;
      mac_en_q  <= mac_en_d;
      mac_clr_q <= mac_clr_d;
      z_we_q    <= z_we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign x_ind_o = i_cnt;
  assign y_ind_o = y_ind_q;
  assign z_ind_o = z_cnt;
  assign mac_clr = mac_clr_q;
  assign mac_en  = mac_en_q;
  assign z_we    = z_we_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: per-cycle schedule model plus per-run aggregate checks.
module tb_conv_seq_ctrl;
  localparam int MAXS = 32;
  localparam int MASK = 63;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [5:0] size_x = '0, size_y = '0;
  logic [5:0] x_ind_o, y_ind_o, z_ind_o;
  logic       mac_clr, mac_en, z_we, busy, done, err;

  always #5 clk = ~clk;

  conv_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .size_x(size_x), .size_y(size_y),
    .x_ind_o(x_ind_o), .y_ind_o(y_ind_o), .z_ind_o(z_ind_o),
    .mac_clr(mac_clr), .mac_en(mac_en), .z_we(z_we),
    .busy(busy), .done(done), .err(err)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    bit busy, clr, en, we, dn, cx, cy;
    int x, y, z;
  } exp_t;

  exp_t q[$];
  exp_t e, idle_e;
  bit   cur_busy = 0, zero_pend = 0, err_pend = 0;
  int   busy_tot = 0, wr_tot = 0, err_tot = 0, last_z = -1, mac_cnt = 0;
  int   macs[64];

  function automatic bit term(input int z, input int i, input int sy);
    return (z - i >= 0) && (z - i < sy);
  endfunction

  task automatic push(input bit b, input bit c, input bit en, input bit we, input bit dn,
                      input bit cx, input bit cy, input int x, input int y, input int z);
    exp_t t;
    t.busy = b; t.clr = c; t.en = en; t.we = we; t.dn = dn;
    t.cx = cx; t.cy = cy; t.x = x; t.y = y; t.z = z;
    q.push_back(t);
  endtask

  // Each output: clear, size_x term cycles, drain, write; one done cycle at the end.
  task automatic build(input int sx, input int sy);
    for (int z = 0; z <= sx + sy - 2; z++) begin
      push(1, 1, 0, 0, 0, 1, 0, 0, 0, z);
      for (int i = 0; i < sx; i++)
        push(1, 0, (i > 0) && term(z, i - 1, sy), 0, 0, 1, 1, i, (z - i) & MASK, z);
      push(1, 0, term(z, sx - 1, sy), 0, 0, 0, 0, 0, 0, z);
      push(1, 0, 0, 1, 0, 0, 0, 0, 0, z);
    end
    push(1, 0, 0, 0, 1, 0, 0, 0, 0, sx + sy - 2);
  endtask

  always begin
    @(posedge clk);
    err_pend  = 0;
    zero_pend = 0;
    if (rst) begin
      q.delete();
      zero_pend = 1;
    end else if (!cur_busy && start) begin
      if (size_x == 0 || size_x > MAXS || size_y == 0 || size_y > MAXS) err_pend = 1;
      else build(int'(size_x), int'(size_y));
    end
    @(negedge clk);
    e = idle_e;
    if (q.size() > 0) e = q.pop_front();
    cur_busy = e.busy;
    chk("busy", busy, e.busy);
    chk("mac_clr", mac_clr, e.clr);
    chk("mac_en", mac_en, e.en);
    chk("z_we", z_we, e.we);
    chk("done", done, e.dn);
    chk("err", err, err_pend);
    if (zero_pend) begin
      chk("rst_x", x_ind_o, 0);
      chk("rst_y", y_ind_o, 0);
      chk("rst_z", z_ind_o, 0);
    end else begin
      if (e.cx)   chk("x_ind", x_ind_o, e.x);
      if (e.cy)   chk("y_ind", y_ind_o, e.y);
      if (e.busy) chk("z_ind", z_ind_o, e.z);
    end
    if (busy)    busy_tot++;
    if (err)     err_tot++;
    if (mac_clr) mac_cnt = 0;
    if (mac_en)  mac_cnt++;
    if (z_we) begin
      macs[z_ind_o] = mac_cnt;
      wr_tot++;
      last_z = int'(z_ind_o);
    end
  end

  task automatic pulse(input int sx, input int sy);
    @(posedge clk); #1;
    size_x = sx[5:0]; size_y = sy[5:0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_chk(input int sx, input int sy, input bit dbl,
                         output int dbusy, output int dwr);
    int b_busy, b_wr, lo, hi;
    bit got;
    b_busy = busy_tot; b_wr = wr_tot; got = 0;
    pulse(sx, sy);
    if (dbl) begin
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    for (int c = 0; c < 4000 && !got; c++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    chk("done_seen", got, 1);
    @(posedge clk); #1;
    dbusy = busy_tot - b_busy;
    dwr   = wr_tot - b_wr;
    chk("busy_cycles", dbusy, (sx + sy - 1) * (sx + 3) + 1);
    chk("writes", dwr, sx + sy - 1);
    chk("last_z", last_z, sx + sy - 2);
    for (int z = 0; z <= sx + sy - 2; z++) begin
      lo = (z - sy + 1 > 0) ? z - sy + 1 : 0;
      hi = (z < sx - 1) ? z : sx - 1;
      chk($sformatf("macs_z%0d", z), macs[z], hi - lo + 1);
    end
  endtask

  task automatic rej(input int sx, input int sy);
    int be, bb, bw;
    be = err_tot; bb = busy_tot; bw = wr_tot;
    pulse(sx, sy);
    repeat (3) @(posedge clk);
    #1;
    chk("rej_err_pulses", err_tot - be, 1);
    chk("rej_busy", busy_tot - bb, 0);
    chk("rej_writes", wr_tot - bw, 0);
  endtask

  initial begin
    int db, dw;
    bit got;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_mac_en", mac_en, 0);
    chk("reset_z_we", z_we, 0);
    chk("reset_x", x_ind_o, 0);
    @(posedge clk); #1 rst = 1'b0;

    run_chk(1, 1, 0, db, dw);
    chk("s11_busy_lit", db, 5);
    chk("s11_wr_lit", dw, 1);
    chk("s11_mac0_lit", macs[0], 1);

    run_chk(3, 2, 0, db, dw);
    chk("s32_busy_lit", db, 25);
    chk("s32_wr_lit", dw, 4);
    chk("s32_mac0_lit", macs[0], 1);
    chk("s32_mac1_lit", macs[1], 2);
    chk("s32_mac2_lit", macs[2], 2);
    chk("s32_mac3_lit", macs[3], 1);

    run_chk(4, 2, 0, db, dw);
    run_chk(2, 4, 0, db, dw);

    rej(0, 5);
    rej(4, 33);
    rej(33, 1);

    run_chk(2, 3, 1, db, dw);
    chk("dbl_start_wr_lit", dw, 4);

    pulse(3, 3);
    got = 0;
    for (int c = 0; c < 500 && !got; c++) begin
      @(negedge clk);
      if (mac_clr && z_ind_o == 6'd2) got = 1;
    end
    chk("reach_z2", got, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_mac_en", mac_en, 0);
    chk("midrst_z", z_ind_o, 0);
    chk("midrst_x", x_ind_o, 0);
    run_chk(2, 2, 0, db, dw);
    chk("restart_wr_lit", dw, 3);

    run_chk(32, 32, 0, db, dw);
    chk("s3232_wr_lit", dw, 63);
    chk("s3232_lastz_lit", last_z, 62);
    chk("s3232_mac31_lit", macs[31], 32);
    chk("s3232_busy_lit", db, 2206);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/conv_seq_ctrl.md
CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 The block SHALL have parameter IDX_W, default 6, giving the index width of x, y and z.
REQ-002 The block SHALL have parameter MAX_SIZE, default 32, giving the maximum accepted size_x and size_y.
REQ-003 Port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port start, input, 1 bit: a one-cycle request to begin a convolution.
REQ-006 Port size_x, input, IDX_W bits: length of the x sequence.
REQ-007 Port size_y, input, IDX_W bits: length of the y sequence.
REQ-008 Port x_ind_o, output, IDX_W bits: registered x memory read index.
REQ-009 Port y_ind_o, output, IDX_W bits: registered y memory read index.
REQ-010 Port z_ind_o, output, IDX_W bits: registered z memory write index.
REQ-011 Port mac_clr, output, 1 bit: clears the external accumulator.
REQ-012 Port mac_en, output, 1 bit: accumulate the product of the current x and y read data.
REQ-013 Port z_we, output, 1 bit: z memory write strobe.
REQ-014 Port busy, output, 1 bit: high in every state other than IDLE.
REQ-015 Port done, output, 1 bit: one-cycle completion pulse.
REQ-016 Port err, output, 1 bit: one-cycle pulse when a start is rejected.

Function
REQ-017 The computation SHALL be z[k] = sum over i of x[i]*y[k-i], for k = 0..size_x+size_y-2 and i = 0..size_x-1, using only terms with 0 <= k-i < size_y.
REQ-018 The FSM SHALL have exactly these states: IDLE, CLR, RUN, DRAIN, WRITE, DONE.
REQ-019 IDLE -> CLR when start=1 and both sizes are in 1..MAX_SIZE; this latches size_x, size_y and sets z_ind_o=0.
REQ-020 When start=1 in IDLE and either size is 0 or >MAX_SIZE, the block SHALL pulse err for 1 cycle and stay in IDLE.
REQ-021 start SHALL be ignored in every state other than IDLE.
REQ-022 CLR SHALL last 1 cycle with mac_clr=1 and x_ind_o=0, then go to RUN.
REQ-023 RUN SHALL last size_x cycles; in RUN cycle i, x_ind_o=i and y_ind_o=z-i (low IDX_W bits of a 7-bit signed difference).
REQ-024 Each RUN cycle SHALL compute term valid = (z-i >= 0) && (z-i < size_y).
REQ-025 Read latency is 1 cycle, so mac_en SHALL equal that valid delayed by exactly 1 cycle; mac_en=0 for invalid terms.
REQ-026 RUN SHALL be followed by DRAIN (1 cycle, carries the last mac_en), then WRITE (1 cycle, z_we=1 with z_ind_o=z).
REQ-027 After WRITE: if z = size_x+size_y-2 the FSM SHALL go to DONE; otherwise z increments and the FSM goes to CLR.
REQ-028 DONE SHALL last 1 cycle with done=1, then return to IDLE; z_ind_o holds its last value.
REQ-029 Each output sample SHALL take size_x+3 cycles; total busy cycles SHALL be (size_x+size_y-1)*(size_x+3)+1.
REQ-030 Index arithmetic SHALL never wrap: the maximum z is 62, which fits in 6 bits.
REQ-031 mac_clr, mac_en, z_we, done and err SHALL never be asserted together, except mac_en during the DRAIN/WRITE overlap described above (mac_en in DRAIN only).

Reset
REQ-032 When rst=1 at a clock edge, the FSM SHALL go to IDLE and all outputs and indices SHALL be 0 on the next cycle, including mid-operation.
REQ-033 The delayed-valid pipeline SHALL be cleared by reset, so no mac_en occurs after reset.

Structure
REQ-034 A shared package conv_pkg SHALL hold the state encoding constants, MAX_SIZE and IDX_W.
REQ-035 One sub-module, idx_cnt, SHALL be used for the i and z counters (clr, en, load value, terminal-count flag), instantiated twice.
REQ-036 All outputs SHALL be registered.

Verification
REQ-037 Scenario: size_x=1, size_y=1, start -> one CLR/RUN/DRAIN/WRITE, z_we with z_ind_o=0, done 5 cycles after CLR entry, busy for 5 cycles.
REQ-038 Scenario: size_x=3, size_y=2 -> 4 writes at z=0..3; the mac_en counts per z are 1,2,2,1; done after 25 busy cycles.
REQ-039 Scenario: size_x=0 or size_y=33 with start -> err pulse 1 cycle, busy stays 0, no writes.
REQ-040 Scenario: start pulsed again during RUN -> ignored; the write count equals that of a single run.
REQ-041 Scenario: rst asserted in RUN of z=2 -> next cycle all outputs 0 and IDLE; a new start then restarts at z=0.
REQ-042 Scenario: size_x=32, size_y=32 -> 63 writes, last z_ind_o=62, mac_en count at z=31 equals 32, no index wrap.
